// File: rtl/bcp_clause_sweeper.sv
// ---------------------------------------------------------------------------
// bcp_clause_sweeper
//
// Initiator side of the BCP processing-element interface. Holds a small
// clause store and, for every accepted decision literal, presents each live
// clause (valid and not yet satisfied) to a single combinational PE, one slot
// per clock. The PE response for the presented slot is consumed in the same
// cycle:
//   done     -> slot marked satisfied, clause left as is
//   conflict -> sticky conflict flag + slot index, sweep aborted
//   imply    -> implied literal pushed into the implication FIFO and the
//               pruned clause written back; a full FIFO stalls the slot
//   none     -> pruned clause written back
// Slots that are empty or already satisfied are presented as an all-zero
// clause and skipped without looking at the PE response.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   load_valid/idx/clause  clause store write port (IDLE only)
//   dec_valid/ready/lit    decision literal handshake (ready only in IDLE)
//   pe_lit, pe_clause      literal and clause presented to the PE
//   pe_pr_clause, pe_imply, pe_imply_idx, pe_done, pe_conflict
//                          combinational PE response for the presented slot
//   imp_valid/ready/lit    implication FIFO head (pop on valid && ready)
//   busy                   sweeper not in IDLE
//   sweep_done             one-cycle pulse while in FINISH
//   conflict, conflict_idx sticky conflict flag and the slot that caused it
//   all_sat                every valid slot satisfied, updated at sweep end
// ---------------------------------------------------------------------------
module bcp_clause_sweeper #(
   parameter int LIT_W       = 11,
   parameter int CLA_LENGTH  = 3,
   parameter int NUM_CLAUSES = 16,
   parameter int IMP_DEPTH   = 8
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 load_valid,
   input  logic [$clog2(NUM_CLAUSES)-1:0]       load_idx,
   input  logic [CLA_LENGTH*LIT_W-1:0]          load_clause,
   input  logic                                 dec_valid,
   output logic                                 dec_ready,
   input  logic signed [LIT_W-1:0]              dec_lit,
   output logic signed [LIT_W-1:0]              pe_lit,
   output logic [CLA_LENGTH*LIT_W-1:0]          pe_clause,
   input  logic [CLA_LENGTH*LIT_W-1:0]          pe_pr_clause,
   input  logic                                 pe_imply,
   input  logic signed [LIT_W-1:0]              pe_imply_idx,
   input  logic                                 pe_done,
   input  logic                                 pe_conflict,
   output logic                                 imp_valid,
   input  logic                                 imp_ready,
   output logic signed [LIT_W-1:0]              imp_lit,
   output logic                                 busy,
   output logic                                 sweep_done,
   output logic                                 conflict,
   output logic [$clog2(NUM_CLAUSES)-1:0]       conflict_idx,
   output logic                                 all_sat
);

   localparam int IDX_W = $clog2(NUM_CLAUSES);
   localparam int PTR_W = $clog2(IMP_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int CLA_W = CLA_LENGTH * LIT_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SWEEP  = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t                  state;
   logic [IDX_W-1:0]        idx;
   logic signed [LIT_W-1:0] lit_q;

   logic [NUM_CLAUSES-1:0]  slot_valid;
   logic [NUM_CLAUSES-1:0]  slot_sat;
   logic [CLA_W-1:0]        store [NUM_CLAUSES];

   logic signed [LIT_W-1:0] fifo_mem [IMP_DEPTH];
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic [CNT_W-1:0]        fifo_cnt;

   logic                    in_sweep;
   logic                    accept;
   logic                    start_sweep;
   logic                    start_noop;
   logic                    load_en;
   logic                    slot_live;
   logic                    fifo_full;
   logic                    last_slot;
   logic                    commit;
   logic                    wb;
   logic                    push;
   logic                    pop;
   logic                    mark_sat;
   logic                    abort;
   logic                    sweep_end;
   logic [NUM_CLAUSES-1:0]  valid_nxt;
   logic [NUM_CLAUSES-1:0]  sat_nxt;
   logic                    all_sat_nxt;

   assign in_sweep    = (state == SWEEP);
   assign dec_ready   = (state == IDLE);
   assign busy        = (state != IDLE);
   assign accept      = dec_valid && dec_ready;
   assign start_sweep = accept && (dec_lit != '0);
   assign start_noop  = accept && (dec_lit == '0);
   assign load_en     = load_valid && (state == IDLE);
   assign slot_live   = slot_valid[idx] && !slot_sat[idx];
   assign last_slot   = (idx == IDX_W'(NUM_CLAUSES - 1));

   // The full test deliberately uses the count before any same-cycle pop.
   assign fifo_full   = (fifo_cnt == CNT_W'(IMP_DEPTH));
   assign imp_valid   = (fifo_cnt != '0);
   assign imp_lit     = imp_valid ? fifo_mem[rd_ptr] : '0;
   assign pop         = imp_valid && imp_ready;

   assign pe_lit      = in_sweep ? lit_q : '0;
   assign pe_clause   = (in_sweep && slot_live) ? store[idx] : '0;

   // Slot response decode: done > conflict > imply > plain prune.
   always_comb begin
      commit   = 1'b0;
      wb       = 1'b0;
      push     = 1'b0;
      mark_sat = 1'b0;
      abort    = 1'b0;
      if (in_sweep) begin
         if (!slot_live) begin
            commit = 1'b1;
         end else if (pe_done) begin
            mark_sat = 1'b1;
            commit   = 1'b1;
         end else if (pe_conflict) begin
            abort = 1'b1;
         end else if (pe_imply) begin
            if (!fifo_full) begin
               push   = 1'b1;
               wb     = 1'b1;
               commit = 1'b1;
            end
         end else begin
            wb     = 1'b1;
            commit = 1'b1;
         end
      end
   end

   assign sweep_end = (commit && last_slot) || abort || start_noop;

   // Next-cycle slot flags, so all_sat can be captured on the same edge that
   // commits the final slot.
   always_comb begin
      valid_nxt = slot_valid;
      sat_nxt   = slot_sat;
      if (load_en) begin
         valid_nxt[load_idx] = |load_clause;
         sat_nxt[load_idx]   = 1'b0;
      end
      if (mark_sat) begin
         sat_nxt[idx] = 1'b1;
      end
   end

   assign all_sat_nxt = (|valid_nxt) && (&(sat_nxt | ~valid_nxt));

   // Control state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         idx          <= '0;
         slot_valid   <= '0;
         slot_sat     <= '0;
         sweep_done   <= 1'b0;
         conflict     <= 1'b0;
         conflict_idx <= '0;
         all_sat      <= 1'b0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_cnt     <= '0;
      end else begin
         slot_valid <= valid_nxt;
         slot_sat   <= sat_nxt;
         sweep_done <= sweep_end;
         if (sweep_end) begin
            all_sat <= all_sat_nxt;
         end
         if (accept) begin
            conflict <= 1'b0;
         end
         if (abort) begin
            conflict     <= 1'b1;
            conflict_idx <= idx;
         end

         case (state)
            IDLE: begin
               if (start_sweep) begin
                  state <= SWEEP;
                  idx   <= '0;
               end else if (start_noop) begin
                  state <= FINISH;
               end
            end
            SWEEP: begin
               if (abort) begin
                  state <= FINISH;
               end else if (commit) begin
                  if (last_slot) begin
                     state <= FINISH;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            FINISH: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase

         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // Datapath storage: contents are qualified by the control flags above.
   always_ff @(posedge clk) begin
      if (start_sweep) begin
         lit_q <= dec_lit;
      end
      if (load_en) begin
         store[load_idx] <= load_clause;
      end else if (wb) begin
         store[idx] <= pe_pr_clause;
      end
      if (push) begin
         fifo_mem[wr_ptr] <= pe_imply_idx;
      end
   end

endmodule

// File: tb/tb_bcp_clause_sweeper.sv
module tb_bcp_clause_sweeper;

   localparam int LW = 11;
   localparam int CL = 3;
   localparam int CW = LW * CL;
   localparam int NC = 16;
   localparam int IW = 4;

   logic                 clk;
   logic                 rst_n;
   logic                 load_valid;
   logic [IW-1:0]        load_idx;
   logic [CW-1:0]        load_clause;
   logic                 dec_valid;
   logic                 dec_ready;
   logic signed [LW-1:0] dec_lit;
   logic signed [LW-1:0] pe_lit;
   logic [CW-1:0]        pe_clause;
   logic [CW-1:0]        pe_pr_clause;
   logic                 pe_imply;
   logic signed [LW-1:0] pe_imply_idx;
   logic                 pe_done;
   logic                 pe_conflict;
   logic                 imp_valid;
   logic                 imp_ready;
   logic signed [LW-1:0] imp_lit;
   logic                 busy;
   logic                 sweep_done;
   logic                 conflict;
   logic [IW-1:0]        conflict_idx;
   logic                 all_sat;

   int tests  = 0;
   int failed = 0;
   int n;
   logic [CW-1:0]        seen     [64];
   logic signed [LW-1:0] seen_lit [64];

   bcp_clause_sweeper #(
      .LIT_W(LW), .CLA_LENGTH(CL), .NUM_CLAUSES(NC), .IMP_DEPTH(8)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .load_valid(load_valid), .load_idx(load_idx), .load_clause(load_clause),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_lit(dec_lit),
      .pe_lit(pe_lit), .pe_clause(pe_clause), .pe_pr_clause(pe_pr_clause),
      .pe_imply(pe_imply), .pe_imply_idx(pe_imply_idx),
      .pe_done(pe_done), .pe_conflict(pe_conflict),
      .imp_valid(imp_valid), .imp_ready(imp_ready), .imp_lit(imp_lit),
      .busy(busy), .sweep_done(sweep_done), .conflict(conflict),
      .conflict_idx(conflict_idx), .all_sat(all_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference PE: satisfied if it holds the literal, otherwise drop the
   // negated literal; nothing left -> conflict, one left -> implication.
   always_comb begin
      logic signed [LW-1:0] l;
      logic signed [LW-1:0] last;
      int nz;
      pe_pr_clause = pe_clause;
      pe_done      = 1'b0;
      pe_conflict  = 1'b0;
      pe_imply     = 1'b0;
      pe_imply_idx = '0;
      l            = '0;
      last         = '0;
      nz           = 0;
      for (int k = 0; k < CL; k++) begin
         l = pe_clause[k*LW +: LW];
         if (l != 0 && l == pe_lit) pe_done = 1'b1;
         if (l != 0 && l == -pe_lit) pe_pr_clause[k*LW +: LW] = '0;
      end
      for (int k = 0; k < CL; k++) begin
         l = pe_pr_clause[k*LW +: LW];
         if (l != 0) begin
            nz++;
            last = l;
         end
      end
      if (!pe_done) begin
         if (nz == 0) pe_conflict = 1'b1;
         else if (nz == 1) begin
            pe_imply     = 1'b1;
            pe_imply_idx = last;
         end
      end
   end

   function automatic logic [CW-1:0] mk(input int a, input int b, input int c);
      mk = {11'(c), 11'(b), 11'(a)};
   endfunction

   task automatic check(input string tag, input longint obs, input longint exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int idx, input logic [CW-1:0] c);
      load_valid  = 1'b1;
      load_idx    = IW'(idx);
      load_clause = c;
      tick();
      load_valid  = 1'b0;
   endtask

   task automatic decide(input int lit);
      dec_valid = 1'b1;
      dec_lit   = LW'(lit);
      tick();
      dec_valid = 1'b0;
      dec_lit   = '0;
   endtask

   // Records the presented clause each cycle until sweep_done (bounded).
   task automatic run_sweep(output int cnt);
      cnt = 0;
      while (!sweep_done && cnt < 60) begin
         seen[cnt]     = pe_clause;
         seen_lit[cnt] = pe_lit;
         tick();
         cnt++;
      end
   endtask

   initial begin
      rst_n = 1'b0; load_valid = 1'b0; load_idx = '0; load_clause = '0;
      dec_valid = 1'b0; dec_lit = '0; imp_ready = 1'b0;

      // Reset state
      #12;
      check("rst_busy", busy, 0);
      check("rst_sweep_done", sweep_done, 0);
      check("rst_conflict", conflict, 0);
      check("rst_conflict_idx", conflict_idx, 0);
      check("rst_all_sat", all_sat, 0);
      check("rst_imp_valid", imp_valid, 0);
      check("rst_pe_lit", pe_lit, 0);
      check("rst_pe_clause", pe_clause, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("dec_ready_idle", dec_ready, 1);

      // Implication with writeback
      load(0, mk(5, -7, 0));
      load(1, mk(3, 4, 0));
      decide(7);
      check("t1_busy", busy, 1);
      check("t1_dec_ready", dec_ready, 0);
      run_sweep(n);
      check("t1_latency", n, 16);
      check("t1_pe_lit", seen_lit[0], 7);
      check("t1_slot0", seen[0], mk(5, -7, 0));
      check("t1_slot1", seen[1], mk(3, 4, 0));
      check("t1_slot2_empty", seen[2], 0);
      check("t1_all_sat", all_sat, 0);
      check("t1_conflict", conflict, 0);
      check("t1_imp_valid", imp_valid, 1);
      check("t1_imp_lit", imp_lit, 5);
      tick();
      check("t1_pulse", sweep_done, 0);
      check("t1_idle", busy, 0);
      imp_ready = 1'b1; tick(); imp_ready = 1'b0;
      check("t1_popped", imp_valid, 0);
      decide(100);
      run_sweep(n);
      check("t1_wb_slot0", seen[0], mk(5, 0, 0));
      check("t1_wb_slot1", seen[1], mk(3, 4, 0));
      check("t1_reimply", imp_lit, 5);
      imp_ready = 1'b1; tick(); imp_ready = 1'b0;

      // Satisfied clause, then skip on a later sweep
      load(0, mk(2, 9, 0));
      load(1, mk(0, 0, 0));
      decide(9);
      run_sweep(n);
      check("t2_latency", n, 16);
      check("t2_all_sat", all_sat, 1);
      check("t2_no_push", imp_valid, 0);
      decide(-2);
      run_sweep(n);
      check("t2_skip_slot0", seen[0], 0);
      check("t2_skip_no_push", imp_valid, 0);
      check("t2_all_sat_kept", all_sat, 1);

      // Conflict abort
      load(3, mk(-4, 0, 0));
      decide(4);
      run_sweep(n);
      check("t3_abort_latency", n, 4);
      check("t3_slot3", seen[3], mk(-4, 0, 0));
      check("t3_conflict", conflict, 1);
      check("t3_conflict_idx", conflict_idx, 3);
      check("t3_all_sat", all_sat, 0);
      tick();
      check("t3_sticky", conflict, 1);
      decide(50);
      check("t3_cleared", conflict, 0);
      run_sweep(n);
      check("t3_full_sweep", n, 16);
      check("t3_neg_imply", imp_lit, -4);
      imp_ready = 1'b1; tick(); imp_ready = 1'b0;

      // FIFO full stall and in-order drain
      load(0, mk(0, 0, 0));
      load(3, mk(0, 0, 0));
      for (int k = 2; k <= 11; k++) load(k - 2, mk(k, -1, 0));
      decide(1);
      for (int i = 0; i < 8; i++) tick();
      check("t4_stall_slot", pe_clause, mk(10, -1, 0));
      for (int i = 0; i < 3; i++) tick();
      check("t4_stall_busy", busy, 1);
      check("t4_stall_held", pe_clause, mk(10, -1, 0));
      imp_ready = 1'b1;
      for (int j = 0; j < 10; j++) begin
         check($sformatf("t4_pop%0d", j), imp_lit, j + 2);
         tick();
      end
      imp_ready = 1'b0;
      check("t4_drained", imp_valid, 0);
      n = 0;
      while (busy && n < 40) begin tick(); n++; end
      check("t4_finished", busy, 0);

      // Reset mid-sweep
      decide(1);
      tick(); tick(); tick();
      check("t5_pre_pushes", imp_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_busy", busy, 0);
      check("t5_imp_valid", imp_valid, 0);
      check("t5_conflict", conflict, 0);
      check("t5_pe_lit", pe_lit, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Empty store after reset; loads during a sweep are ignored
      decide(5);
      load_valid = 1'b1; load_idx = '0; load_clause = mk(-5, 0, 0);
      tick(); tick();
      load_valid = 1'b0;
      run_sweep(n);
      check("t5_latency", n, 14);
      check("t5_all_sat", all_sat, 0);
      check("t5_no_push", imp_valid, 0);
      check("t5_no_conflict", conflict, 0);
      tick();

      // Zero decision: no-op sweep
      decide(0);
      check("t6_noop_done", sweep_done, 1);
      check("t6_noop_busy", busy, 1);
      check("t6_noop_all_sat", all_sat, 0);
      tick();
      check("t6_noop_idle", busy, 0);
      decide(5);
      run_sweep(n);
      check("t6_latency", n, 16);
      check("t6_slot0_empty", seen[0], 0);
      check("t6_load_ignored", conflict, 0);
      check("t6_no_push", imp_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
